// File: rtl/alu_exec.sv
// Multi-cycle execute unit: single-cycle add/sub/shift/rotate plus iterative
// shift-add multiply and restoring divide behind a start/busy/done handshake.
module alu_exec #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_zero,
  output logic             illegal,
  output logic             busy,
  output logic             done
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_ROL  = 4'b0111;
  localparam logic [3:0] OP_ROR  = 4'b1000;
  localparam logic [3:0] OP_ADDR = 4'b1001;
  localparam logic [3:0] OP_BCMP = 4'b1010;

  typedef enum logic {S_IDLE, S_ITER} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] hi_q, hi_d;    // mul: upper product / div: remainder
  logic [WIDTH-1:0] lo_q, lo_d;    // mul: lower product / div: dividend->quotient
  logic [WIDTH-1:0] opnd_q, opnd_d; // mul: multiplicand / div: divisor

  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             div_zero_q, div_zero_d;
  logic             illegal_q, illegal_d;
  logic             done_q, done_d;

  // Single-cycle datapath
  logic [SW-1:0]      amt;
  logic [2*WIDTH-1:0] dbl_l, dbl_r;
  logic [WIDTH-1:0]   sc_res, sc_hi;
  logic               sc_dz, sc_ill, long_op;

  // Doubling the operand makes the upper/lower halves yield rotate and shift together.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    amt     = b[SW-1:0];
    dbl_l   = {a, a} << amt;
    dbl_r   = {a, a} >> amt;
    sc_res  = '0;
    sc_hi   = '0;
    sc_dz   = 1'b0;
    sc_ill  = 1'b0;
    long_op = 1'b0;
    case (alu_control)
      OP_ADD, OP_ADDR: sc_res = a + b;
      OP_SUB, OP_BCMP: sc_res = a - b;
      OP_MUL:          long_op = 1'b1;
      OP_DIV: begin
        if (b == '0) begin
          sc_res = '1;
          sc_hi  = a;
          sc_dz  = 1'b1;
        end else begin
          long_op = 1'b1;
        end
      end
      OP_SLL:  sc_res = dbl_l[WIDTH-1:0];
      OP_SRL:  sc_res = dbl_r[2*WIDTH-1:WIDTH];
      OP_ROL:  sc_res = dbl_l[2*WIDTH-1:WIDTH];
      OP_ROR:  sc_res = dbl_r[WIDTH-1:0];
      default: sc_ill = 1'b1;
    endcase
  end

  // One iteration step of each engine
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi, div_lo;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi    = mul_sum[WIDTH:1];
    mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    // Remainder stays below the divisor, so the W-bit difference is exact.
    div_hi    = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
    div_lo    = {lo_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    div_zero_d  = div_zero_q;
    illegal_d   = illegal_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (long_op) begin
            is_div_d = (alu_control == OP_DIV);
            hi_d     = '0;
            lo_d     = (alu_control == OP_DIV) ? a : b;
            opnd_d   = (alu_control == OP_DIV) ? b : a;
            cnt_d    = '0;
            state_d  = S_ITER;
          end else begin
            result_d    = sc_res;
            result_hi_d = sc_hi;
            zero_d      = (sc_res == '0);
            div_zero_d  = sc_dz;
            illegal_d   = sc_ill;
            done_d      = 1'b1;
          end
        end
      end
      S_ITER: begin
        hi_d  = is_div_q ? div_hi : mul_hi;
        lo_d  = is_div_q ? div_lo : mul_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SW'(WIDTH - 1)) begin
          result_d    = lo_d;
          result_hi_d = hi_d;
          zero_d      = (lo_d == '0);
          div_zero_d  = 1'b0;
          illegal_d   = 1'b0;
          done_d      = 1'b1;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      illegal_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      div_zero_q  <= div_zero_d;
      illegal_q   <= illegal_d;
      done_q      <= done_d;
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign div_zero  = div_zero_q;
  assign illegal   = illegal_q;
  assign busy      = (state_q == S_ITER);
  assign done      = done_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: vector table plus scoreboard queue, and
// hand-written sequences for back-to-back, ignored start and mid-op reset.
module tb_alu_exec;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   alu_control;
  logic [W-1:0] a, b, result, result_hi;
  logic         zero, div_zero, illegal, busy, done;

  alu_exec #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
    .a(a), .b(b), .result(result), .result_hi(result_hi), .zero(zero),
    .div_zero(div_zero), .illegal(illegal), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, r, rh;
    logic         z, dz, il;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[12];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [3:0] op, input logic [W-1:0] av, bv, r, rh,
                               input logic z, dz, il);
    vec_t v;
    v.op = op; v.a = av; v.b = bv; v.r = r; v.rh = rh; v.z = z; v.dz = dz; v.il = il;
    return v;
  endfunction

  // Reference behaviour built from plain operators and bit-at-a-time rotation.
  function automatic vec_t model(input logic [3:0] op, input logic [W-1:0] av, bv);
    vec_t v;
    logic [2*W-1:0] p;
    logic [W-1:0] t;
    int amt;
    v.op = op; v.a = av; v.b = bv; v.r = '0; v.rh = '0; v.dz = 1'b0; v.il = 1'b0;
    amt = int'(bv) % W;
    t = av;
    case (op)
      4'd0, 4'd9:  v.r = av + bv;
      4'd1, 4'd10: v.r = av - bv;
      4'd3: begin p = {16'b0, av} * {16'b0, bv}; v.r = p[W-1:0]; v.rh = p[2*W-1:W]; end
      4'd4: begin
        if (bv == 0) begin v.r = '1; v.rh = av; v.dz = 1'b1; end
        else begin v.r = av / bv; v.rh = av % bv; end
      end
      4'd5: v.r = av << amt;
      4'd6: v.r = av >> amt;
      4'd7: begin repeat (amt) t = {t[W-2:0], t[W-1]}; v.r = t; end
      4'd8: begin repeat (amt) t = {t[0], t[W-1:1]}; v.r = t; end
      default: v.il = 1'b1;
    endcase
    v.z = (v.r == 0);
    return v;
  endfunction

  task automatic drive(input logic [3:0] op_i, input logic [W-1:0] a_i, b_i);
    alu_control = op_i; a = a_i; b = b_i; start = 1'b1;
  endtask

  task automatic check_out(input string tag);
    vec_t v;
    if (exp_q.size() == 0) begin
      check({tag, " unexpected done"}, 32'd1, 32'd0);
      return;
    end
    v = exp_q.pop_front();
    check({tag, " result"},    32'(result),    32'(v.r));
    check({tag, " result_hi"}, 32'(result_hi), 32'(v.rh));
    check({tag, " zero"},      32'(zero),      32'(v.z));
    check({tag, " div_zero"},  32'(div_zero),  32'(v.dz));
    check({tag, " illegal"},   32'(illegal),   32'(v.il));
  endtask

  task automatic run(input vec_t v, input string tag);
    logic is_long, got, busy_ok;
    int   lat;
    is_long = (v.op == 4'd3) || (v.op == 4'd4 && v.b != 0);
    lat     = is_long ? W + 1 : 1;
    got     = 1'b0;
    busy_ok = 1'b1;
    @(negedge clk);
    drive(v.op, v.a, v.b);
    exp_q.push_back(v);
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (done) begin
        got = 1'b1;
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " busy at done"}, 32'(busy), 32'd0);
        check_out(tag);
      end else if (busy !== is_long) begin
        busy_ok = 1'b0;
      end
    end
    if (!got) begin
      check({tag, " timeout"}, 32'd0, 32'd1);
      exp_q.delete();
    end
    check({tag, " busy profile"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    check({tag, " done pulse width"}, 32'(done), 32'd0);
  endtask

  logic [3:0] ops[10] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};

  initial begin
    logic ok, seen;
    rst = 1'b1; start = 1'b0; alu_control = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset result", 32'(result), 32'd0);
    check("reset result_hi", 32'(result_hi), 32'd0);
    check("reset flags", 32'({zero, div_zero, illegal, busy, done}), 32'd0);
    rst = 1'b0;

    tbl[0]  = mkv(4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 0, 0, 0);
    tbl[1]  = mkv(4'b0100, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 0, 0, 0);
    tbl[2]  = mkv(4'b0100, 16'h00FF, 16'h0000, 16'hFFFF, 16'h00FF, 0, 1, 0);
    tbl[3]  = mkv(4'b0010, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1, 0, 1);
    tbl[4]  = mkv(4'b1111, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1, 0, 1);
    tbl[5]  = mkv(4'b0011, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 0, 0);
    tbl[6]  = mkv(4'b0101, 16'h0001, 16'h0013, 16'h0008, 16'h0000, 0, 0, 0);
    tbl[7]  = mkv(4'b0110, 16'h8000, 16'h0010, 16'h8000, 16'h0000, 0, 0, 0);
    tbl[8]  = mkv(4'b1000, 16'h0001, 16'h0001, 16'h8000, 16'h0000, 0, 0, 0);
    tbl[9]  = mkv(4'b0001, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 0, 0, 0);
    tbl[10] = mkv(4'b1001, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1, 0, 0);
    tbl[11] = mkv(4'b0100, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1, 0, 0);
    for (int i = 0; i < 12; i++) run(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = (i % 3 == 0) ? W'($urandom_range(1, 40)) : W'($urandom);
      run(model(ops[$urandom_range(0, 9)], ra, rb), $sformatf("rand%0d", i));
    end

    // Back-to-back: second start issued in the cycle the first done is high.
    @(negedge clk);
    drive(4'b1010, 16'h1234, 16'h1234);
    exp_q.push_back(mkv(4'b1010, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 1, 0, 0));
    @(negedge clk);
    check("b2b first done", 32'(done), 32'd1);
    check_out("b2b bcmp");
    drive(4'b0111, 16'h8001, 16'h0004);
    exp_q.push_back(mkv(4'b0111, 16'h8001, 16'h0004, 16'h0018, 16'h0000, 0, 0, 0));
    @(negedge clk);
    start = 1'b0;
    check("b2b second done", 32'(done), 32'd1);
    check_out("b2b rol");
    @(negedge clk);
    check("b2b idle", 32'(done), 32'd0);

    // Multiply with a stray start at T+5 that must be ignored.
    @(negedge clk);
    drive(4'b0011, 16'h1234, 16'h0100);
    exp_q.push_back(mkv(4'b0011, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 0, 0, 0));
    ok = 1'b1;
    for (int n = 1; n <= W + 1; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 5) drive(4'b0000, 16'h0000, 16'h0000);
      if (n == 6) start = 1'b0;
      if (n <= W) begin
        if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
      end else begin
        check("mul done", 32'(done), 32'd1);
        check("mul busy at done", 32'(busy), 32'd0);
        check_out("mul");
      end
    end
    check("mul busy window", 32'(ok), 32'd1);
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (done) seen = 1'b1; end
    check("mul ignored start", 32'(seen), 32'd0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    drive(4'b0011, 16'h1234, 16'h0100);
    seen = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 5) rst = 1'b1;
      if (n == 6) begin
        rst = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst result_hi", 32'(result_hi), 32'd0);
        check("rst flags", 32'({zero, div_zero, illegal, done}), 32'd0);
      end
      if (done) seen = 1'b1;
    end
    check("rst no done", 32'(seen), 32'd0);
    run(mkv(4'b0000, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 0, 0, 0), "post-rst add");

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
